// File: rtl/btn_pkg.sv
// btn_pkg -- shared definitions for the push-button event generator.
//
// Contents:
//   btn_state_t  per-channel debounce FSM state (2 bits)
//   DEF_*        default values for the btn_event_gen parameters
//   max_int      helper used to size the optional auto-repeat counter
//
// Optional feature macro used by the files that import this package:
//   BTN_REPEAT_EN  enables press_pulse auto-repeat while a button is held.

package btn_pkg;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      PRESS_WAIT = 2'd1,
      HELD       = 2'd2,
      REL_WAIT   = 2'd3
   } btn_state_t;

   localparam int DEF_TICK_DIV        = 100000;  // 1 ms tick at 100 MHz
   localparam int DEF_DB_TICKS        = 10;
   localparam int DEF_REP_DELAY_TICKS = 500;
   localparam int DEF_REP_RATE_TICKS  = 100;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/btn_chan.sv
// btn_chan -- one push-button channel: 2-FF synchroniser, tick-based
// debounce FSM and registered one-clock press/release pulses.
//
// Ports:
//   clk            system clock, rising edge
//   rst_n          asynchronous active-low reset
//   tick           one-clock debounce tick from the shared prescaler
//   btn            raw asynchronous button input, active high
//   level          debounced level
//   press_pulse    one-clock pulse on accepted press (and auto-repeat)
//   release_pulse  one-clock pulse on accepted release
//
// Macro BTN_REPEAT_EN: when defined, press_pulse repeats after
// REP_DELAY_TICKS ticks in HELD and then every REP_RATE_TICKS ticks.

module btn_chan
   import btn_pkg::*;
#(
   parameter int DB_TICKS        = DEF_DB_TICKS,
   parameter int REP_DELAY_TICKS = DEF_REP_DELAY_TICKS,
   parameter int REP_RATE_TICKS  = DEF_REP_RATE_TICKS
) (
   input  logic clk,
   input  logic rst_n,
   input  logic tick,
   input  logic btn,
   output logic level,
   output logic press_pulse,
   output logic release_pulse
);

   localparam int CNT_W = $clog2(DB_TICKS + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_TICKS - 1);

   logic             meta;
   logic             sync;
   btn_state_t       state;
   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= 1'b0;
         sync <= 1'b0;
      end else begin
         meta <= btn;
         sync <= meta;
      end
   end

`ifdef BTN_REPEAT_EN
   localparam int REP_W = $clog2(max_int(REP_DELAY_TICKS, REP_RATE_TICKS) + 1);
   localparam logic [REP_W-1:0] REP_DELAY = REP_W'(REP_DELAY_TICKS);
   localparam logic [REP_W-1:0] REP_RATE  = REP_W'(REP_RATE_TICKS);

   logic [REP_W-1:0] rep_cnt;
   logic             rep_armed;  // first repeat already issued -> use rate
   logic [REP_W-1:0] rep_next;
   logic             rep_hit;

   assign rep_next = rep_cnt + REP_W'(1);
   assign rep_hit  = rep_armed ? (rep_next == REP_RATE) : (rep_next == REP_DELAY);
`else
   // Repeat parameters have no effect when auto-repeat is not built.
   if (REP_DELAY_TICKS < 1 || REP_RATE_TICKS < 1) begin : g_rep_unused
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         cnt           <= '0;
         level         <= 1'b0;
         press_pulse   <= 1'b0;
         release_pulse <= 1'b0;
`ifdef BTN_REPEAT_EN
         rep_cnt       <= '0;
         rep_armed     <= 1'b0;
`endif
      end else begin
         press_pulse   <= 1'b0;
         release_pulse <= 1'b0;
         case (state)
            IDLE: begin
               if (sync) begin
                  state <= PRESS_WAIT;
                  cnt   <= '0;
               end
            end
            PRESS_WAIT: begin
               if (!sync) begin
                  state <= IDLE;
               end else if (tick) begin
                  if (cnt == CNT_LAST) begin
                     state       <= HELD;
                     level       <= 1'b1;
                     press_pulse <= 1'b1;
`ifdef BTN_REPEAT_EN
                     rep_cnt     <= '0;
                     rep_armed   <= 1'b0;
`endif
                  end else begin
                     cnt <= cnt + CNT_W'(1);
                  end
               end
            end
            HELD: begin
               if (!sync) begin
                  state <= REL_WAIT;
                  cnt   <= '0;
               end
`ifdef BTN_REPEAT_EN
               // Repeat count survives short release bounces (REL_WAIT holds it).
               else if (tick) begin
                  if (rep_hit) begin
                     press_pulse <= 1'b1;
                     rep_cnt     <= '0;
                     rep_armed   <= 1'b1;
                  end else begin
                     rep_cnt <= rep_next;
                  end
               end
`endif
            end
            REL_WAIT: begin
               if (sync) begin
                  state <= HELD;
               end else if (tick) begin
                  if (cnt == CNT_LAST) begin
                     state         <= IDLE;
                     level         <= 1'b0;
                     release_pulse <= 1'b1;
                  end else begin
                     cnt <= cnt + CNT_W'(1);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: rtl/btn_event_gen.sv
// btn_event_gen -- multi-channel push-button front end.
// Shared debounce-tick prescaler plus N_CH independent btn_chan instances.
//
// Ports:
//   clk            system clock, rising edge
//   rst_n          asynchronous active-low reset
//   btn_in         raw button inputs, active high, asynchronous
//   btn_level      debounced level per channel
//   press_pulse    one-clock pulse per channel on accepted press / repeat
//   release_pulse  one-clock pulse per channel on accepted release
//   any_press      OR of press_pulse (registered bits, so glitch-free)
//
// Macro BTN_REPEAT_EN: enables press_pulse auto-repeat in every channel.

module btn_event_gen
   import btn_pkg::*;
#(
   parameter int N_CH            = 4,
   parameter int TICK_DIV        = DEF_TICK_DIV,
   parameter int DB_TICKS        = DEF_DB_TICKS,
   parameter int REP_DELAY_TICKS = DEF_REP_DELAY_TICKS,
   parameter int REP_RATE_TICKS  = DEF_REP_RATE_TICKS
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [N_CH-1:0] btn_in,
   output logic [N_CH-1:0] btn_level,
   output logic [N_CH-1:0] press_pulse,
   output logic [N_CH-1:0] release_pulse,
   output logic            any_press
);

   // TICK_DIV=1 keeps a 1-bit counter pinned at 0, so tick is always high.
   localparam int PS_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICK_DIV - 1);

   logic [PS_W-1:0] ps_count;
   logic            tick;

   assign tick = (ps_count == PS_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ps_count <= '0;
      end else if (tick) begin
         ps_count <= '0;
      end else begin
         ps_count <= ps_count + PS_W'(1);
      end
   end

   for (genvar gi = 0; gi < N_CH; gi++) begin : g_chan
      btn_chan #(
         .DB_TICKS        (DB_TICKS),
         .REP_DELAY_TICKS (REP_DELAY_TICKS),
         .REP_RATE_TICKS  (REP_RATE_TICKS)
      ) u_chan (
         .clk           (clk),
         .rst_n         (rst_n),
         .tick          (tick),
         .btn           (btn_in[gi]),
         .level         (btn_level[gi]),
         .press_pulse   (press_pulse[gi]),
         .release_pulse (release_pulse[gi])
      );
   end

   assign any_press = |press_pulse;

endmodule

// File: tb/tb_btn_event_gen.sv
// Bench for btn_event_gen (N_CH=2, TICK_DIV=4, DB_TICKS=3, REP 5/2).
// Reference model: per channel, a level change is accepted once the
// synchronised input has disagreed with the accepted level on consecutive
// clocks and DB_TICKS ticks fell after the first disagreeing clock.
// Outputs are compared every clock, 1 time unit after the rising edge.

module tb_btn_event_gen;

   localparam int N_CH      = 2;
   localparam int TICK_DIV  = 4;
   localparam int DB_TICKS  = 3;
   localparam int REP_DELAY = 5;
   localparam int REP_RATE  = 2;

   logic            clk = 1'b0;
   logic            rst_n = 1'b1;
   logic [N_CH-1:0] btn_in = '0;
   logic [N_CH-1:0] btn_level;
   logic [N_CH-1:0] press_pulse;
   logic [N_CH-1:0] release_pulse;
   logic            any_press;

   always #5 clk = ~clk;

   btn_event_gen #(
      .N_CH            (N_CH),
      .TICK_DIV        (TICK_DIV),
      .DB_TICKS        (DB_TICKS),
      .REP_DELAY_TICKS (REP_DELAY),
      .REP_RATE_TICKS  (REP_RATE)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .btn_in        (btn_in),
      .btn_level     (btn_level),
      .press_pulse   (press_pulse),
      .release_pulse (release_pulse),
      .any_press     (any_press)
   );

   int compared = 0;
   int mismatched = 0;

   // reference model state
   int              m_k;            // clock edges since reset release
   logic [N_CH-1:0] m_s1, m_s2;     // input as seen 1 and 2 clocks ago
   logic [N_CH-1:0] m_level, m_press, m_release;
   int              m_run   [N_CH]; // consecutive clocks sync != level
   int              m_ticks [N_CH]; // ticks counted inside that run
   int              m_held  [N_CH]; // ticks spent held since accept

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_k = 0;
      m_s1 = '0; m_s2 = '0;
      m_level = '0; m_press = '0; m_release = '0;
      for (int c = 0; c < N_CH; c++) begin
         m_run[c] = 0; m_ticks[c] = 0; m_held[c] = 0;
      end
   endtask

   task automatic model_edge(input logic [N_CH-1:0] b);
      logic tk;
      logic s;
      tk = ((m_k % TICK_DIV) == TICK_DIV - 1);
      m_press = '0;
      m_release = '0;
      for (int c = 0; c < N_CH; c++) begin
         s = m_s2[c];
         if (s != m_level[c]) begin
            if (m_run[c] > 0 && tk) m_ticks[c]++;
            m_run[c]++;
            if (m_ticks[c] == DB_TICKS) begin
               m_level[c] = s;
               if (s) begin
                  m_press[c] = 1'b1;
                  m_held[c] = 0;
               end else begin
                  m_release[c] = 1'b1;
               end
               m_run[c] = 0;
               m_ticks[c] = 0;
            end
         end else begin
`ifdef BTN_REPEAT_EN
            if (m_level[c] && m_run[c] == 0 && tk) begin
               m_held[c]++;
               if (m_held[c] == REP_DELAY ||
                   (m_held[c] > REP_DELAY && ((m_held[c] - REP_DELAY) % REP_RATE) == 0))
                  m_press[c] = 1'b1;
            end
`endif
            m_run[c] = 0;
            m_ticks[c] = 0;
         end
      end
      m_s2 = m_s1;
      m_s1 = b;
      m_k++;
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_level"},   32'(btn_level),     32'h0);
      check({tag, "_press"},   32'(press_pulse),   32'h0);
      check({tag, "_release"}, 32'(release_pulse), 32'h0);
      check({tag, "_any"},     32'(any_press),     32'h0);
   endtask

   task automatic step(input string tag);
      @(posedge clk);
      model_edge(btn_in);
      #1;
      check({tag, "_level"},   32'(btn_level),     32'(m_level));
      check({tag, "_press"},   32'(press_pulse),   32'(m_press));
      check({tag, "_release"}, 32'(release_pulse), 32'(m_release));
      check({tag, "_any"},     32'(any_press),     32'(|m_press));
   endtask

   task automatic drive(input string tag, input logic [N_CH-1:0] b, input int n);
      btn_in = b;
      for (int i = 0; i < n; i++) step(tag);
   endtask

   initial begin
      int first_press;
      int rem [N_CH];
      logic [N_CH-1:0] b;

      // power-on reset
      #2 rst_n = 1'b0;
      #1 check_zero("reset");
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      drive("idle", 2'b00, 8);

      // clean press on ch0 with latency window check
      btn_in = 2'b01;
      first_press = -1;
      for (int i = 1; i <= 40; i++) begin
         step("clean_hi");
         if (first_press < 0 && press_pulse[0]) first_press = i;
      end
      check("clean_latency_ok", 32'(first_press >= 11 && first_press <= 15), 32'h1);
      drive("clean_lo", 2'b00, 40);

      // glitch on ch0
      drive("glitch_hi", 2'b01, 5);
      drive("glitch_lo", 2'b00, 30);

      // bounce on ch1, then settle high, then release
      for (int i = 0; i < 10; i++) drive("bounce", (i % 2 == 0) ? 2'b10 : 2'b00, 2);
      drive("bounce_hold", 2'b10, 40);
      drive("bounce_rel", 2'b00, 40);

      // simultaneous rise and fall
      drive("simul_hi", 2'b11, 40);
      drive("simul_lo", 2'b00, 40);

      // reset while ch0 is held, released with ch0 still high
      drive("prehold", 2'b01, 30);
      rst_n = 1'b0;
      #1 check_zero("rst_mid");
      model_reset();
      @(posedge clk);
      #1 check_zero("rst_hold");
      @(negedge clk);
      rst_n = 1'b1;
      drive("after_rst", 2'b01, 60);
      drive("after_rst_lo", 2'b00, 40);

      // randomized independent toggling per channel
      b = '0;
      for (int c = 0; c < N_CH; c++) rem[c] = $urandom_range(1, 24);
      for (int i = 0; i < 600; i++) begin
         for (int c = 0; c < N_CH; c++) begin
            rem[c]--;
            if (rem[c] == 0) begin
               b[c] = ~b[c];
               rem[c] = $urandom_range(1, 24);
            end
         end
         drive("rand", b, 1);
      end
      drive("final", 2'b00, 40);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
